// File: rtl/trdb_pkg.sv
// Shared trace-debugger types and sizes for the E-Trace branch-map logic.
package trdb_pkg;

  localparam int unsigned BRANCH_MAP_LEN = 31;
  localparam int unsigned BRANCH_CNT_W   = 5;

  typedef logic [BRANCH_MAP_LEN-1:0] branch_map_t;
  typedef logic [BRANCH_CNT_W-1:0]   branch_cnt_t;

endpackage

// File: rtl/trdb_branch_map_unit.sv
// Branch-map accumulator: records one outcome bit per retired conditional branch
// (1 = not taken) and counts them until the packet emitter flushes the map.
module trdb_branch_map_unit
  import trdb_pkg::*;
#(
  parameter int unsigned MAP_LEN = BRANCH_MAP_LEN,
  parameter int unsigned CNT_W   = BRANCH_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  input  logic               branch_taken_i,
  input  logic               flush_i,
  output logic [MAP_LEN-1:0] map_o,
  output logic [CNT_W-1:0]   branches_o,
  output logic               is_full_o,
  output logic               is_empty_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAP_LEN);

  logic [MAP_LEN-1:0] r_map;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAP_LEN-1:0] w_mapD;
  logic [CNT_W-1:0]   w_cntD;

  // A branch arriving together with a flush seeds the fresh map instead of being lost.
  always_comb begin
    w_mapD = r_map;
    w_cntD = r_cnt;
    if (flush_i) begin
      w_mapD = '0;
      w_cntD = '0;
      if (valid_i) begin
        w_mapD[0] = ~branch_taken_i;
        w_cntD    = CNT_W'(1);
      end
    end else if (valid_i && (r_cnt < MaxCnt)) begin
      w_mapD[r_cnt] = ~branch_taken_i;
      w_cntD        = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_map <= '0;
      r_cnt <= '0;
    end else begin
      r_map <= w_mapD;
      r_cnt <= w_cntD;
    end
  end

  assign map_o      = r_map;
  assign branches_o = r_cnt;
  assign is_full_o  = (r_cnt == MaxCnt);
  assign is_empty_o = (r_cnt == '0);

  assert property (@(posedge clk_i) disable iff (rst_ni) r_cnt <= MaxCnt);
  assert property (@(posedge clk_i) disable iff (rst_ni) !(is_full_o && is_empty_o));

endmodule

// File: tb/tb_trdb_branch_map_unit.sv
// Self-checking bench for trdb_branch_map_unit: directed scenarios plus random
// traffic, all compared every cycle against a queue-based model of recorded branches.
module tb_trdb_branch_map_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        taken;
  logic        flush;
  logic [30:0] mapO;
  logic [4:0]  branchesO;
  logic        fullO;
  logic        emptyO;

  int checks = 0;
  int errors = 0;

  // Model: the ordered list of stored outcome bits since the last flush/reset.
  bit modelQ[$];

  trdb_branch_map_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst),
    .valid_i       (valid),
    .branch_taken_i(taken),
    .flush_i       (flush),
    .map_o         (mapO),
    .branches_o    (branchesO),
    .is_full_o     (fullO),
    .is_empty_o    (emptyO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] expMap();
    logic [30:0] m;
    m = '0;
    for (int i = 0; i < modelQ.size(); i++) m[i] = modelQ[i];
    return m;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compares every DUT output against the model; called once per cycle.
  task automatic checkOutput();
    compare("map", {1'b0, mapO}, {1'b0, expMap()});
    compare("branches", {27'd0, branchesO}, 32'(modelQ.size()));
    compare("full", {31'd0, fullO}, {31'd0, modelQ.size() == 31});
    compare("empty", {31'd0, emptyO}, {31'd0, modelQ.size() == 0});
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then checks.
  task automatic applyStimulus(input logic r, input logic v, input logic t, input logic f);
    rst   = r;
    valid = v;
    taken = t;
    flush = f;
    @(posedge clk);
    if (r) modelQ.delete();
    else if (f) begin
      modelQ.delete();
      if (v) modelQ.push_back(~t);
    end else if (v && modelQ.size() < 31) modelQ.push_back(~t);
    #1;
    checkOutput();
  endtask

  task automatic pinState(input string name, input logic [30:0] m, input int n,
                          input logic f, input logic e);
    compare({name, "_lit_map"}, {1'b0, mapO}, {1'b0, m});
    compare({name, "_lit_cnt"}, {27'd0, branchesO}, 32'(n));
    compare({name, "_lit_full"}, {31'd0, fullO}, {31'd0, f});
    compare({name, "_lit_empty"}, {31'd0, emptyO}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; taken = 1'b0; flush = 1'b0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    pinState("reset", 31'd0, 0, 1'b0, 1'b1);

    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    pinState("pattern", 31'b010, 3, 1'b0, 1'b0);

    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 31; i++) applyStimulus(0, 1, 0, 0);
    pinState("fill", 31'h7FFF_FFFF, 31, 1'b1, 1'b0);

    applyStimulus(0, 1, 1, 0);
    pinState("overflow", 31'h7FFF_FFFF, 31, 1'b1, 1'b0);

    applyStimulus(0, 1, 0, 1);
    pinState("flushvalid", 31'd1, 1, 1'b0, 1'b0);

    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1'($urandom), 0);
    compare("partial_cnt", {27'd0, branchesO}, 32'd5);
    applyStimulus(0, 0, 1, 1);
    pinState("flush", 31'd0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1'($urandom), 0);
    compare("midreset_pre_cnt", {27'd0, branchesO}, 32'd10);
    applyStimulus(1, 1, 0, 0);
    pinState("midreset", 31'd0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 127) == 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    ($urandom_range(0, 47) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trdb_branch_map_unit.md
Name: trdb_branch_map_unit

Overview:
- Branch-map accumulator for the RISC-V E-Trace encoder.
- Records the outcome of each retired conditional branch as one bit in a map and counts the recorded branches.
- Exposes the map and count to the packet emitter, together with full and empty flags.
- The packet emitter flushes the map after it has emitted a branch-map packet.

Parameters:
- MAP_LEN, 31, number of branch slots in the map (E-Trace maximum).
- CNT_W, 5, width of the branch counter; must satisfy 2^CNT_W > MAP_LEN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-high.
- valid_i  in  1  a conditional branch retires this cycle.
- branch_taken_i  in  1  outcome of that branch; 1 = taken. Only meaningful when valid_i=1.
- flush_i  in  1  clear the map and counter (the map has been consumed).
- map_o  out  MAP_LEN  branch map; bit k holds the outcome of the k-th recorded branch.
- branches_o  out  CNT_W  number of valid bits in map_o.
- is_full_o  out  1  branches_o == MAP_LEN.
- is_empty_o  out  1  branches_o == 0.

Behaviour:
- Registered state: map_q[MAP_LEN-1:0] and cnt_q[CNT_W-1:0].
- Outputs: map_o = map_q and branches_o = cnt_q. is_full_o and is_empty_o are combinational decodes of cnt_q. Results appear one cycle after the inputs are sampled.
- Bit encoding follows E-Trace: a stored bit is ~branch_taken_i, so 1 = not taken and 0 = taken.
- Reset (rst_ni=1 at a rising edge):
  - map_q = 0, cnt_q = 0.
  - Hence is_empty_o = 1 and is_full_o = 0.
  - Reset overrides every other input.
- Next-state priority, applied at each rising edge when not in reset:
  1. flush_i=1 and valid_i=1: map_q = 0 except bit0 = ~branch_taken_i; cnt_q = 1. The new branch starts the fresh map and is not lost.
  2. flush_i=1 and valid_i=0: map_q = 0, cnt_q = 0.
  3. valid_i=1, no flush, cnt_q < MAP_LEN: map_q[cnt_q] = ~branch_taken_i, all other bits held; cnt_q = cnt_q + 1.
  4. valid_i=1, no flush, cnt_q == MAP_LEN (full): the input is dropped and state is held. No wrap-around and no counter overflow. The encoder guarantees a flush is issued when is_full_o=1.
  5. Otherwise: state held.
- Bits at index >= cnt_q are always 0, because flush and reset clear the whole map.
- branch_taken_i is ignored when valid_i=0.
- The block has no handshake and no backpressure.
- Expected implementation size is about 120-200 lines including assertions:
  - cnt_q <= MAP_LEN always;
  - is_full_o and is_empty_o never both 1.

Decomposition:
- Shared package trdb_pkg:
  - BRANCH_MAP_LEN = 31
  - BRANCH_CNT_W = 5
  - typedef branch_map_t as logic[30:0]
  - typedef branch_cnt_t as logic[4:0]
- The parameter defaults are taken from this package.
- No sub-module; a single always_ff plus a next-state always_comb.

Test Plan:
- Reset: hold rst_ni=1 for 2 cycles -> map_o=0, branches_o=0, is_empty_o=1, is_full_o=0.
- Fill pattern: 3 valid cycles with taken=1,0,1 -> map_o=...010 (bit1=1), branches_o=3, is_empty_o=0.
- Fill to full: 31 valid cycles with taken=0 -> map_o=all ones, branches_o=31, is_full_o=1.
- Overflow: then one more valid cycle with taken=1 -> map_o and branches_o unchanged.
- Flush: flush_i=1, valid_i=0 on a partially filled map (branches_o=5) -> next cycle map_o=0, branches_o=0, is_empty_o=1.
- Simultaneous flush and valid: on a full map, apply flush_i=1, valid_i=1, taken=0 -> map_o=1, branches_o=1, is_full_o=0, is_empty_o=0.
- Mid-operation reset: rst_ni=1 with valid_i=1 and branches_o=10 -> map_o=0, branches_o=0; the branch is not recorded.
